key_note_mapper: RTL and testbench
==================================

KEY_NOTE_MAPPER -- requirements
Module: key_note_mapper

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 100000, meaning consecutive stable cycles before a key change is accepted.
REQ-002 SHALL have parameter SUSTAIN_CYCLES, default 25000000, meaning post-release note hold length (used only under KEY_SUSTAIN_EN).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  free-play mode; low while key mappings are being adjusted.
REQ-006 SHALL have port key_in  input  7  raw, unsynchronised key switches.
REQ-007 SHALL have ports key_mapping_0..key_mapping_6  input  7 each  one-hot key assigned to notes 1..7.
REQ-008 SHALL have port note_out  output  4  current note, 0 = silent, 1..7 = note.
REQ-009 SHALL have port note_valid  output  1  high whenever note_out != 0.
REQ-010 SHALL have port note_start  output  1  one-cycle pulse on every new or changed note.
REQ-011 SHALL have port conflict  output  1  debounced key vector has more than one bit set.

Function
REQ-012 SHALL pass key_in through a 2-flop synchroniser per bit.
REQ-013 SHALL update the debounced vector only after the synchronised vector is unchanged for DEBOUNCE_CYCLES consecutive cycles; any change restarts the count.
REQ-014 SHALL compute the matched note as i+1 for the lowest i where (debounced & key_mapping_i) != 0; 0 if none.
REQ-015 SHALL treat an all-zero mapping as matching nothing.
REQ-016 SHALL treat overlapping mappings by the lowest-index rule in REQ-014.
REQ-017 SHALL register note_out, so note_out reflects a debounced change one cycle later; total raw-to-note latency is 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-018 SHALL implement states IDLE, PLAYING and SUSTAIN; SUSTAIN is reachable only under KEY_SUSTAIN_EN.
REQ-019 SHALL transition IDLE->PLAYING when enable=1 and the matched note != 0; note_out takes the matched note and note_start pulses.
REQ-020 SHALL, in PLAYING, load and pulse note_start when the matched note changes to another nonzero value.
REQ-021 SHALL transition PLAYING->IDLE (or ->SUSTAIN with the macro) when the matched note becomes 0.
REQ-022 SHALL re-evaluate the mappings every cycle; a mapping change that alters the matched note behaves as a key change.
REQ-023 SHALL force IDLE, note_out=0, note_start=0, and clear sustain count within one cycle whenever enable=0, from any state; the debouncer keeps running.
REQ-024 SHALL assert conflict combinationally from the debounced vector, independent of enable.

Reset
REQ-025 SHALL, on reset low, asynchronously set state=IDLE, note_out=0, note_valid=0, note_start=0, synchroniser/debounced vector=0, and counters=0.
REQ-026 SHALL resume only on the first clk edge after reset deasserts; an in-progress debounce or sustain is discarded.

Configuration
REQ-027 SHALL, with KEY_SUSTAIN_EN defined, hold the last note for SUSTAIN_CYCLES after release in SUSTAIN, return to IDLE on expiry, and go to PLAYING with note_start on a new match during SUSTAIN.
REQ-028 SHALL, without KEY_SUSTAIN_EN, drop note_out to 0 in the same cycle the release is registered and omit the sustain counter.

Structure
REQ-029 SHALL place NUM_KEYS=7, NOTE_W=4, NOTE_SILENT=0 and the state encoding typedef in shared package cosmic_pkg.
REQ-030 SHALL implement the synchroniser and debouncer as sub-module key_debouncer (width NUM_KEYS), instantiated once.

Verification (DEBOUNCE_CYCLES=4, SUSTAIN_CYCLES=8, identity mapping key_mapping_i=1<<i)
REQ-031 SHALL cover: key_in=7'b0000100 held -> note_out=3 and a single note_start exactly 7 cycles after the edge.
REQ-032 SHALL cover: key_in toggles every 2 cycles for 20 cycles -> note_out stays 0 and no note_start.
REQ-033 SHALL cover: key_in=7'b0000110 -> conflict=1 and note_out=2; then key_in=7'b0000010 -> conflict=0, note_out stays 2, no new note_start.
REQ-034 SHALL cover: playing note 5, then enable=0 -> note_out=0 next cycle; with enable=1 and the key still held -> note 5 returns with note_start.
REQ-035 SHALL cover: KEY_SUSTAIN_EN, release of note 4 -> note_out=4 for 8 cycles then 0; a repress within the window -> note_start with no gap.
REQ-036 SHALL cover: reset low mid-debounce and mid-play -> all outputs 0 immediately, no note_start after release until a full debounce period.

Source files
------------

// File: rtl/cosmic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cosmic_pkg
//  Purpose  : Shared key/note widths, FSM state encoding and note matcher.
//  Revision : 1.0  initial release
// ============================================================================
package cosmic_pkg;

    localparam int NUM_KEYS = 7;
    localparam int NOTE_W   = 4;
    localparam logic [NOTE_W-1:0] NOTE_SILENT = '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_SUSTAIN = 2'd2
    } note_state_t;

    typedef logic [NUM_KEYS-1:0]               key_vec_t;
    typedef logic [NUM_KEYS-1:0][NUM_KEYS-1:0] key_map_t;

    // Lowest mapping index that hits a pressed key wins; empty mappings never hit.
    function automatic logic [NOTE_W-1:0] match_note(input key_vec_t keys, input key_map_t maps);
        logic [NOTE_W-1:0] note;
        note = NOTE_SILENT;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if ((keys & maps[i]) != '0) begin
                note = NOTE_W'(i + 1);
            end
        end
        return note;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : key_debouncer
//  Purpose  : Two-flop synchroniser plus stable-count debouncer per key vector.
//  Revision : 1.0  initial release
// ============================================================================
module key_debouncer #(
    parameter int WIDTH           = 7,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] debounced
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [WIDTH-1:0]   r_deb;
    logic [c_CNT_W-1:0] r_cnt;

    // A difference between the two sync stages means r_sync2 changes on this
    // edge, so the stability count restarts from the new value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
            if ((r_sync1 != r_sync2) || (r_sync2 == r_deb)) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign debounced = r_deb;

endmodule
`default_nettype wire

// File: rtl/key_note_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : key_note_mapper
//  Purpose  : Maps debounced keys through programmable one-hot mappings to a
//             note number; KEY_SUSTAIN_EN adds a post-release sustain hold.
//  Revision : 1.0  initial release
// ============================================================================
module key_note_mapper
    import cosmic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int SUSTAIN_CYCLES  = 25000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic [NUM_KEYS-1:0] key_mapping_0,
    input  logic [NUM_KEYS-1:0] key_mapping_1,
    input  logic [NUM_KEYS-1:0] key_mapping_2,
    input  logic [NUM_KEYS-1:0] key_mapping_3,
    input  logic [NUM_KEYS-1:0] key_mapping_4,
    input  logic [NUM_KEYS-1:0] key_mapping_5,
    input  logic [NUM_KEYS-1:0] key_mapping_6,
    output logic [NOTE_W-1:0]   note_out,
    output logic                note_valid,
    output logic                note_start,
    output logic                conflict
);

    key_vec_t          w_deb;
    key_map_t          w_maps;
    logic [NOTE_W-1:0] w_match;

    note_state_t       r_state;
    note_state_t       w_state_nxt;
    logic [NOTE_W-1:0] r_note;
    logic [NOTE_W-1:0] w_note_nxt;
    logic              r_start;
    logic              w_start_nxt;

`ifdef KEY_SUSTAIN_EN
    localparam int c_SUS_W = (SUSTAIN_CYCLES > 1) ? $clog2(SUSTAIN_CYCLES) : 1;
    localparam logic [c_SUS_W-1:0] c_SUS_LAST = c_SUS_W'(SUSTAIN_CYCLES - 1);

    logic [c_SUS_W-1:0] r_sus;
    logic [c_SUS_W-1:0] w_sus_nxt;
`endif

    key_debouncer #(
        .WIDTH           (NUM_KEYS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (key_in),
        .debounced (w_deb)
    );

    assign w_maps  = {key_mapping_6, key_mapping_5, key_mapping_4, key_mapping_3,
                      key_mapping_2, key_mapping_1, key_mapping_0};
    assign w_match = match_note(w_deb, w_maps);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_note  <= NOTE_SILENT;
            r_start <= 1'b0;
`ifdef KEY_SUSTAIN_EN
            r_sus   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_note  <= w_note_nxt;
            r_start <= w_start_nxt;
`ifdef KEY_SUSTAIN_EN
            r_sus   <= w_sus_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_note_nxt  = r_note;
        w_start_nxt = 1'b0;
`ifdef KEY_SUSTAIN_EN
        w_sus_nxt   = r_sus;
`endif
        if (!enable) begin
            // Mapping adjustment mode silences everything; the debouncer keeps tracking keys.
            w_state_nxt = ST_IDLE;
            w_note_nxt  = NOTE_SILENT;
`ifdef KEY_SUSTAIN_EN
            w_sus_nxt   = '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_match != NOTE_SILENT) begin
                        w_state_nxt = ST_PLAYING;
                        w_note_nxt  = w_match;
                        w_start_nxt = 1'b1;
                    end
                end
                ST_PLAYING: begin
                    if (w_match == NOTE_SILENT) begin
`ifdef KEY_SUSTAIN_EN
                        w_state_nxt = ST_SUSTAIN;
                        w_sus_nxt   = '0;
`else
                        w_state_nxt = ST_IDLE;
                        w_note_nxt  = NOTE_SILENT;
`endif
                    end else if (w_match != r_note) begin
                        w_note_nxt  = w_match;
                        w_start_nxt = 1'b1;
                    end
                end
`ifdef KEY_SUSTAIN_EN
                ST_SUSTAIN: begin
                    // A new press takes priority over expiry so a repress never leaves a gap.
                    if (w_match != NOTE_SILENT) begin
                        w_state_nxt = ST_PLAYING;
                        w_note_nxt  = w_match;
                        w_start_nxt = 1'b1;
                        w_sus_nxt   = '0;
                    end else if (r_sus == c_SUS_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_note_nxt  = NOTE_SILENT;
                        w_sus_nxt   = '0;
                    end else begin
                        w_sus_nxt   = r_sus + c_SUS_W'(1);
                    end
                end
`endif
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_note_nxt  = NOTE_SILENT;
                end
            endcase
        end
    end

    assign note_out   = r_note;
    assign note_valid = (r_note != NOTE_SILENT);
    assign note_start = r_start;
    assign conflict   = ((w_deb & (w_deb - key_vec_t'(1))) != '0);

endmodule
`default_nettype wire

// File: tb/tb_key_note_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_note_mapper
//  Purpose  : Scoreboard bench for key_note_mapper (debounce 4, sustain 8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_note_mapper;

    typedef struct {
        logic [3:0] note;
        int         cyc;
    } ev_t;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [6:0] key_in;
    logic [6:0] km0, km1, km2, km3, km4, km5, km6;
    logic [3:0] note_out;
    logic       note_valid;
    logic       note_start;
    logic       conflict;

    int  cyc;
    int  checks;
    int  errors;
    ev_t sb[$];
    ev_t ev;

    key_note_mapper #(
        .DEBOUNCE_CYCLES (4),
        .SUSTAIN_CYCLES  (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .key_in        (key_in),
        .key_mapping_0 (km0),
        .key_mapping_1 (km1),
        .key_mapping_2 (km2),
        .key_mapping_3 (km3),
        .key_mapping_4 (km4),
        .key_mapping_5 (km5),
        .key_mapping_6 (km6),
        .note_out      (note_out),
        .note_valid    (note_valid),
        .note_start    (note_start),
        .conflict      (conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every note_start must match the oldest expected event exactly.
    always @(negedge clk) begin
        if (reset) begin
            if (note_start) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_start: pulse with note_out=%0d at cycle %0d, required no pulse",
                             note_out, cyc);
                end else begin
                    ev = sb.pop_front();
                    if (note_out !== ev.note || cyc != ev.cyc) begin
                        errors++;
                        $display("FAIL start_event: got note %0d at cycle %0d, required note %0d at cycle %0d",
                                 note_out, cyc, ev.note, ev.cyc);
                    end
                end
            end
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_start: no pulse for note %0d due at cycle %0d (now %0d)",
                         sb[0].note, sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_start(input logic [3:0] note, input int delay);
        sb.push_back('{note: note, cyc: cyc + delay});
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        enable = 1'b1;
        key_in = '0;
        km0 = 7'b0000001; km1 = 7'b0000010; km2 = 7'b0000100; km3 = 7'b0001000;
        km4 = 7'b0010000; km5 = 7'b0100000; km6 = 7'b1000000;

        tick(3);
        chk("reset_note_out",   note_out,   0);
        chk("reset_note_valid", note_valid, 0);
        chk("reset_note_start", note_start, 0);
        chk("reset_conflict",   conflict,   0);
        reset = 1'b1;
        tick(3);

        // Single key, 7-cycle latency, then mapping edits while held.
        key_in = 7'b0000100;
        expect_start(4'd3, 7);
        tick(10);
        chk("note3_out",      note_out,   3);
        chk("note3_valid",    note_valid, 1);
        chk("note3_conflict", conflict,   0);
        km0 = 7'b0000100;
        expect_start(4'd1, 1);
        tick(2);
        chk("overlap_lowest_index", note_out, 1);
        km0 = 7'b0000000;
        expect_start(4'd3, 1);
        tick(2);
        chk("empty_mapping_ignored", note_out, 3);
        km0 = 7'b0000001;
        tick(1);
        key_in = '0;
        tick(20);
        chk("note3_released", note_out, 0);

        // Bouncing key never settles long enough.
        for (int i = 0; i < 10; i++) begin
            key_in = (i % 2 == 0) ? 7'b0000001 : 7'b0000000;
            tick(2);
        end
        tick(10);
        chk("bounce_silent", note_out, 0);

        // Two keys: conflict flagged, lowest mapping wins.
        key_in = 7'b0000110;
        expect_start(4'd2, 7);
        tick(10);
        chk("conflict_set",  conflict, 1);
        chk("conflict_note", note_out, 2);
        key_in = 7'b0000010;
        tick(10);
        chk("conflict_clear", conflict, 0);
        chk("conflict_keep",  note_out, 2);
        key_in = '0;
        tick(20);

        // Enable drop silences next cycle; re-enable replays the held key.
        key_in = 7'b0010000;
        expect_start(4'd5, 7);
        tick(10);
        chk("note5_out", note_out, 5);
        enable = 1'b0;
        tick(1);
        chk("disable_note",  note_out,   0);
        chk("disable_valid", note_valid, 0);
        tick(3);
        enable = 1'b1;
        expect_start(4'd5, 1);
        tick(3);
        chk("reenable_note", note_out, 5);
        key_in = '0;
        tick(20);

`ifdef KEY_SUSTAIN_EN
        key_in = 7'b0001000;
        expect_start(4'd4, 7);
        tick(10);
        key_in = '0;
        tick(14);
        chk("sustain_hold",   note_out, 4);
        tick(1);
        chk("sustain_expire", note_out, 0);
        key_in = 7'b0001000;
        expect_start(4'd4, 7);
        tick(10);
        key_in = '0;
        tick(6);
        key_in = 7'b0001000;
        expect_start(4'd4, 7);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("sustain_no_gap", note_out, 4);
        end
`else
        key_in = 7'b0001000;
        expect_start(4'd4, 7);
        tick(10);
        key_in = '0;
        tick(6);
        chk("release_hold", note_out, 4);
        tick(1);
        chk("release_drop", note_out, 0);
        tick(5);
`endif

        // Reset in the middle of play and of a debounce.
        key_in = 7'b0000001;
        expect_start(4'd1, 7);
        tick(10);
        chk("note1_out", note_out, 1);
        key_in = 7'b0000010;
        tick(2);
        reset = 1'b0;
        #1;
        chk("midreset_note",  note_out,   0);
        chk("midreset_valid", note_valid, 0);
        chk("midreset_start", note_start, 0);
        tick(2);
        reset = 1'b1;
        expect_start(4'd2, 7);
        tick(6);
        chk("postreset_not_early", note_out, 0);
        tick(4);
        chk("postreset_note", note_out, 2);
        key_in = '0;
        tick(20);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
